// File: rtl/result_bcd_converter.sv
// rtl/result_bcd_converter.sv - signed binary to BCD converter, one double-dabble step per cycle
module result_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  negative,
  output logic [4*DIGITS-1:0]   digits
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sign_q, sign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             negative_q, negative_d;
  logic [BW-1:0]    digits_q, digits_d;

  logic [WIDTH-1:0] magnitude;
  logic [BW-1:0]    adjusted;
  logic [BW-1:0]    shifted;

  // Unsigned magnitude of the operand; the most negative value maps onto its own bit pattern.
  always_comb begin
    magnitude = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
  end

  // Add-3 correction on every BCD digit that would overflow past 9 when doubled, then shift in one binary bit.
  always_comb begin
    adjusted = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adjusted[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? (scratch_q[4*i +: 4] + 4'd3)
                                                         : scratch_q[4*i +: 4];
    end
    shifted = {adjusted[BW-2:0], shift_q[WIDTH-1]};
  end

  // Next-state and datapath control; done is a single-cycle pulse and the result registers load only on completion.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    sign_d     = sign_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    negative_d = negative_q;
    digits_d   = digits_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          shift_d   = magnitude;
          sign_d    = value[WIDTH-1];
          scratch_d = '0;
          count_d   = '0;
          busy_d    = 1'b1;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        scratch_d = shifted;
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        count_d   = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          digits_d   = shifted;
          negative_d = sign_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any conversion in flight and clears the visible result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      sign_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      negative_q <= 1'b0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      sign_q     <= sign_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      negative_q <= negative_d;
      digits_q   <= digits_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign negative = negative_q;
  assign digits   = digits_q;

endmodule
